hilo_muldiv_seq: RTL

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the architectural HI/LO pair.

---
 rtl/hilo_muldiv_seq_pkg.sv | 35 +++
 rtl/hilo_muldiv_seq_if.sv | 28 ++
 rtl/hilo_muldiv_seq_step.sv | 38 +++
 rtl/hilo_muldiv_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int CW   = $clog2(XLEN);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a two's complement value when take is set, otherwise the raw bits.
  function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] v, input logic take);
    return (take && v[XLEN-1]) ? neg_x(v) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// EX-stage <-> HI/LO sequencer signal bundle.
interface hilo_muldiv_seq_if;
  import muldiv_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            abort;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic            div0;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, abort, mthi, mtlo, wdata,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, abort, mthi, mtlo, wdata,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_seq_step.sv
// One iteration of shift-add multiply or restoring divide on the {upper, lower} accumulator.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic              qbit
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] diff_s;

  // Multiply adds the multiplicand on a set LSB then shifts right; divide shifts left and
  // keeps the trial difference when it does not borrow. The quotient bit leaves via qbit.
  always_comb begin
    sum_s    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    rem_sh_s = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, opnd};
    qbit     = 1'b0;
    acc_nxt  = {sum_s, acc[XLEN-1:1]};
    if (is_div) begin
      if (!diff_s[XLEN]) begin
        qbit    = 1'b1;
        acc_nxt = {diff_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        qbit    = 1'b0;
        acc_nxt = {rem_sh_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      qbit    = 1'b0;
      acc_nxt = {sum_s, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Bit-serial MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO pair.
module hilo_muldiv_seq
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  hilo_muldiv_seq_if.slave  bus
);

  state_e            state_r, state_nxt_s;
  logic [1:0]        op_r;
  logic [XLEN-1:0]   rs_r, rt_r, opnd_r;
  logic [2*XLEN-1:0] acc_r;
  logic [CW-1:0]     cnt_r;
  logic              neg_res_r, neg_rem_r, dz_r;
  logic              busy_r, done_r, div0_r;
  logic [XLEN-1:0]   hi_r, lo_r;

  logic              accept_s, abort_s, is_div_s, is_signed_s;
  logic [XLEN-1:0]   mag_rs_s, mag_rt_s;
  logic [2*XLEN-1:0] step_acc_s, prod_s;
  logic              step_q_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  assign accept_s    = bus.start && !bus.abort && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign abort_s     = bus.abort && (state_r != S_IDLE);
  assign is_div_s    = op_r[1];
  assign is_signed_s = !op_r[0];
  // A zero divisor skips sign handling so the dividend bits fall straight through to HI.
  assign mag_rs_s    = mag_of(rs_r, is_signed_s && !dz_r);
  assign mag_rt_s    = mag_of(rt_r, is_signed_s && !dz_r);
  assign prod_s      = neg_res_r ? neg_2x(acc_r) : acc_r;
  assign quo_s       = neg_res_r ? neg_x(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
  assign rem_s       = neg_rem_r ? neg_x(acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];

  muldiv_step u_step (
    .acc     (acc_r),
    .opnd    (opnd_r),
    .is_div  (is_div_s),
    .acc_nxt (step_acc_s),
    .qbit    (step_q_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort returns to IDLE from any active state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nxt_s = S_PREP;
        else          state_nxt_s = S_IDLE;
      end
      S_PREP: begin
        if (abort_s) state_nxt_s = S_IDLE;
        else         state_nxt_s = S_ITER;
      end
      S_ITER: begin
        if (abort_s)            state_nxt_s = S_IDLE;
        else if (cnt_r == '0)   state_nxt_s = S_FIX;
        else                    state_nxt_s = S_ITER;
      end
      S_FIX: begin
        if (abort_s) state_nxt_s = S_IDLE;
        else         state_nxt_s = S_DONE;
      end
      S_DONE: begin
        if (accept_s) state_nxt_s = S_PREP;
        else          state_nxt_s = S_IDLE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand capture, magnitude preparation and the iterating accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= 2'b00;
      rs_r      <= '0;
      rt_r      <= '0;
      opnd_r    <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            op_r <= bus.op;
            rs_r <= bus.rs_val;
            rt_r <= bus.rt_val;
            dz_r <= bus.op[1] && (bus.rt_val == '0);
          end
        end
        S_PREP: begin
          opnd_r    <= is_div_s ? mag_rt_s : mag_rs_s;
          acc_r     <= {{XLEN{1'b0}}, (is_div_s ? mag_rs_s : mag_rt_s)};
          cnt_r     <= CW'(XLEN - 1);
          neg_res_r <= is_signed_s && !dz_r && (rs_r[XLEN-1] ^ rt_r[XLEN-1]);
          neg_rem_r <= is_signed_s && !dz_r && is_div_s && rs_r[XLEN-1];
        end
        S_ITER: begin
          acc_r <= is_div_s ? {step_acc_s[2*XLEN-1:1], step_q_s} : step_acc_s;
          cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Handshake outputs: busy from acceptance until FIX completes, done/div0 pulse in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
    end else if (abort_s) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
    end else begin
      done_r <= (state_r == S_FIX);
      div0_r <= (state_r == S_FIX) && dz_r;
      if (accept_s)               busy_r <= 1'b1;
      else if (state_r == S_FIX)  busy_r <= 1'b0;
      else                        busy_r <= busy_r;
    end
  end

  // HI/LO: result commit at the end of FIX, otherwise direct writes while not busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if ((state_r == S_FIX) && !bus.abort) begin
      if (dz_r) begin
        hi_r <= rs_r;
        lo_r <= {XLEN{1'b1}};
      end else if (is_div_s) begin
        hi_r <= rem_s;
        lo_r <= quo_s;
      end else begin
        hi_r <= prod_s[2*XLEN-1:XLEN];
        lo_r <= prod_s[XLEN-1:0];
      end
    end else if (!busy_r) begin
      if (bus.mthi) hi_r <= bus.wdata;
      if (bus.mtlo) lo_r <= bus.wdata;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.div0 = div0_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
